// File: rtl/pwm_duty_sequencer_pkg.sv
// rtl/pwm_duty_sequencer_pkg.sv - shared state encoding and constants for the PWM duty sequencer
package pwm_duty_sequencer_pkg;

    // Command FSM: IDLE accepts commands, PENDING waits for the first period
    // boundary, RAMP keeps stepping duty_active toward the target.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RAMP    = 2'd2
    } seq_state_t;

    // Default counter/duty width and its terminal count.
    localparam int RESOLUTION_BITS_DEFAULT = 8;
    localparam int MAX_VALUE               = (1 << RESOLUTION_BITS_DEFAULT) - 1;

    // Absolute distance between two duty values, one bit wider so the
    // subtraction can never wrap.
    function automatic logic [RESOLUTION_BITS_DEFAULT:0] duty_distance(
        input logic [RESOLUTION_BITS_DEFAULT:0] a,
        input logic [RESOLUTION_BITS_DEFAULT:0] b
    );
        duty_distance = (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - clock prescaler producing the counter advance tick
module pwm_prescaler
    import pwm_duty_sequencer_pkg::*;
#(
    parameter int PRESCALE_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [PRESCALE_BITS-1:0] prescale,
    output logic                     tick
);

    logic [PRESCALE_BITS-1:0] div_cnt;

    // Compare with >= so a prescale lowered below the running count still
    // produces a tick immediately instead of running all the way round.
    assign tick = ena && (div_cnt >= prescale);

    // Divider count: clears on tick, advances only while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else if (ena) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - PWM channel with period counter and boundary-aligned duty ramping
module pwm_duty_sequencer
    import pwm_duty_sequencer_pkg::*;
#(
    parameter int RESOLUTION_BITS = RESOLUTION_BITS_DEFAULT,
    parameter int PRESCALE_BITS   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [PRESCALE_BITS-1:0]   prescale,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [RESOLUTION_BITS-1:0] cmd_duty,
    input  logic [RESOLUTION_BITS-1:0] cmd_step,
    output logic [RESOLUTION_BITS-1:0] count,
    output logic [RESOLUTION_BITS-1:0] duty_active,
    output logic                       pwm_out,
    output logic                       period_tick,
    output logic                       busy
);

    localparam logic [RESOLUTION_BITS-1:0] CNT_MAX = '1;

    seq_state_t                 state;
    logic [RESOLUTION_BITS-1:0] target;
    logic [RESOLUTION_BITS-1:0] step;
    logic                       tick;
    logic                       wrap;

    logic [RESOLUTION_BITS:0]   target_ext;
    logic [RESOLUTION_BITS:0]   duty_ext;
    logic [RESOLUTION_BITS:0]   step_ext;
    logic [RESOLUTION_BITS:0]   diff;
    logic                       ramp_last;
    logic [RESOLUTION_BITS-1:0] duty_stepped;

    pwm_prescaler #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .prescale(prescale),
        .tick    (tick)
    );

    // A period boundary is the tick that takes the counter from MAX back to 0.
    assign wrap = tick && (count == CNT_MAX);

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Next ramp value: jump when no step is set or the remaining distance fits
    // in one step, otherwise move by exactly one step (cannot overshoot).
    always_comb begin
        target_ext   = {1'b0, target};
        duty_ext     = {1'b0, duty_active};
        step_ext     = {1'b0, step};
        diff         = (target_ext >= duty_ext) ? (target_ext - duty_ext)
                                                : (duty_ext - target_ext);
        ramp_last    = (step == '0) || (diff <= step_ext);
        duty_stepped = (target > duty_active) ? (duty_active + step)
                                              : (duty_active - step);
    end

    // Period counter and the wrap pulse, which lines up with count showing 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= wrap;
            if (tick) begin
                count <= (count == CNT_MAX) ? '0 : (count + 1'b1);
            end
        end
    end

    // Registered compare; output forced low while the channel is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= ena && (count < duty_active);
        end
    end

    // Command FSM: latch commands in IDLE, apply them only on period boundaries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            target      <= '0;
            step        <= '0;
            duty_active <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        target <= cmd_duty;
                        step   <= cmd_step;
                        state  <= ST_PENDING;
                    end
                end
                ST_PENDING, ST_RAMP: begin
                    if (wrap) begin
                        if (ramp_last) begin
                            duty_active <= target;
                            state       <= ST_IDLE;
                        end else begin
                            duty_active <= duty_stepped;
                            state       <= ST_RAMP;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
